// File: rtl/rng_roll_if.sv
// rtl/rng_roll_if.sv - button/clear inputs and roll result outputs of rng_roll_ctrl
// RNG_ROLL_COUNT_EN adds the roll_count signal.
interface rng_roll_if #(
    parameter int WIDTH = 10
);
    logic             btn;
    logic             clear;
    logic [WIDTH-1:0] random_num;
    logic             busy;
    logic             valid;
`ifdef RNG_ROLL_COUNT_EN
    logic [7:0]       roll_count;
`endif

    modport master (
        output btn,
        output clear,
        input  random_num,
        input  busy,
        input  valid
`ifdef RNG_ROLL_COUNT_EN
        , input roll_count
`endif
    );

    modport slave (
        input  btn,
        input  clear,
        output random_num,
        output busy,
        output valid
`ifdef RNG_ROLL_COUNT_EN
        , output roll_count
`endif
    );
endinterface

// File: rtl/rng_roll_ctrl.sv
// rtl/rng_roll_ctrl.sv - debounced push-button dice roll sequencer with free-running seed counter
// Optional feature macro: RNG_ROLL_COUNT_EN (saturating count of completed rolls).
module rng_roll_ctrl #(
    parameter int WIDTH        = 10,
    parameter int DEBOUNCE_CYC = 16,
    parameter int ROLL_CYC     = 8,
    parameter int ROLL_DIV     = 4
) (
    input  logic       clk,
    input  logic       rst,
    rng_roll_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ROLL = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam int DB_W  = $clog2(DEBOUNCE_CYC);
    localparam int DIV_W = (ROLL_DIV > 1) ? $clog2(ROLL_DIV) : 1;
    localparam int RC_W  = $clog2(ROLL_CYC + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ROLL_DIV - 1);
    localparam logic [RC_W-1:0]  RC_LOAD  = RC_W'(ROLL_CYC);

    logic [1:0]       state;
    logic [WIDTH-1:0] count;
    logic             btn_s1, btn_s, btn_db, btn_db_q;
    logic [DB_W-1:0]  db_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [RC_W-1:0]  roll_cnt;
    logic [WIDTH-1:0] random_num_r;
    logic             busy_r, valid_r;
    logic             press;
    logic             roll_done;

    assign press     = btn_db & ~btn_db_q;
    assign roll_done = (state == S_ROLL) && (div_cnt == DIV_LAST) && (roll_cnt == RC_W'(1));

    assign bus.random_num = random_num_r;
    assign bus.busy       = busy_r;
    assign bus.valid      = valid_r;

    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else     count <= count + WIDTH'(1);
    end

    // A level is accepted only after DEBOUNCE_CYC consecutive samples that differ from it.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1   <= 1'b0;
            btn_s    <= 1'b0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            db_cnt   <= '0;
        end else begin
            btn_s1   <= bus.btn;
            btn_s    <= btn_s1;
            btn_db_q <= btn_db;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            div_cnt      <= '0;
            roll_cnt     <= '0;
            random_num_r <= '0;
            busy_r       <= 1'b0;
            valid_r      <= 1'b0;
        end else if (bus.clear) begin
            state        <= S_IDLE;
            random_num_r <= '0;
            busy_r       <= 1'b0;
            valid_r      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HOLD: begin
                    if (press) begin
                        state    <= S_ROLL;
                        div_cnt  <= '0;
                        roll_cnt <= RC_LOAD;
                        busy_r   <= 1'b1;
                        valid_r  <= 1'b0;
                    end
                end
                S_ROLL: begin
                    // Presses arriving mid-roll are deliberately dropped.
                    if (div_cnt == DIV_LAST) begin
                        div_cnt      <= '0;
                        random_num_r <= count;
                        roll_cnt     <= roll_cnt - RC_W'(1);
                        if (roll_cnt == RC_W'(1)) begin
                            state   <= S_HOLD;
                            busy_r  <= 1'b0;
                            valid_r <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef RNG_ROLL_COUNT_EN
    logic [7:0] roll_count_r;

    assign bus.roll_count = roll_count_r;

    // Survives clear; only rst returns it to zero.
    always_ff @(posedge clk) begin
        if (rst)
            roll_count_r <= '0;
        else if (!bus.clear && roll_done && (roll_count_r != 8'hFF))
            roll_count_r <= roll_count_r + 8'd1;
    end
`else
    logic unused_roll_done;
    assign unused_roll_done = roll_done;
`endif
endmodule

// File: tb/tb_rng_roll_ctrl.sv
// tb/tb_rng_roll_ctrl.sv - self-checking bench for rng_roll_ctrl
module tb_rng_roll_ctrl;
    localparam int WIDTH    = 10;
    localparam int DEB      = 4;
    localparam int RCYC     = 3;
    localparam int RDIV     = 2;
    localparam int ROLL_LEN = RCYC * RDIV;

    typedef struct {
        int width;
        int clear_at;
        bit exp_roll;
        bit exp_valid;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rng_roll_if #(.WIDTH(WIDTH)) bus ();

    rng_roll_ctrl #(
        .WIDTH(WIDTH), .DEBOUNCE_CYC(DEB), .ROLL_CYC(RCYC), .ROLL_DIV(RDIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;
    logic [WIDTH-1:0] mc;
    logic [WIDTH-1:0] held;
    bit   model_valid;
    int   model_rolls;
    int   lat;

    // Cycles since reset release equals the seed counter value.
    always @(posedge clk) begin
        if (rst) mc <= '0;
        else     mc <= mc + WIDTH'(1);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string name);
        chk({name, " busy"}, int'(bus.busy), 0);
        chk({name, " valid"}, int'(bus.valid), int'(model_valid));
        chk({name, " num"}, int'(bus.random_num), int'(held));
    endtask

    // Drives a btn pulse; returns at the first ROLL cycle or after 40 cycles with no roll.
    task automatic press_and_wait(input int width, input int clr_from, input int clr_to,
                                  output bit rolled, output int l);
        rolled = 1'b0;
        l      = 0;
        bus.btn = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            bus.clear = (i >= clr_from) && (i <= clr_to);
            tick();
            if (i == width) bus.btn = 1'b0;
            if (bus.busy) begin
                rolled = 1'b1;
                l      = i;
                break;
            end
        end
        bus.btn   = 1'b0;
        bus.clear = 1'b0;
    endtask

    // Called at the first ROLL cycle; c is the seed count in that cycle.
    task automatic check_roll(input logic [WIDTH-1:0] c, input int abort_at);
        logic [WIDTH-1:0] prev;
        logic [WIDTH-1:0] exp;
        prev = held;
        for (int n = 0; n < ROLL_LEN; n++) begin
            exp = (n < RDIV) ? prev : WIDTH'(int'(c) + RDIV * (n / RDIV) - 1);
            chk("roll busy", int'(bus.busy), 1);
            chk("roll valid", int'(bus.valid), 0);
            chk("roll num", int'(bus.random_num), int'(exp));
            if (n == abort_at) begin
                bus.clear = 1'b1;
                tick();
                bus.clear   = 1'b0;
                held        = '0;
                model_valid = 1'b0;
                chk_quiet("abort");
                return;
            end
            tick();
        end
        held        = WIDTH'(int'(c) + ROLL_LEN - 1);
        model_valid = 1'b1;
        model_rolls++;
        chk("done busy", int'(bus.busy), 0);
        chk("done valid", int'(bus.valid), 1);
        chk("done num", int'(bus.random_num), int'(held));
    endtask

    task automatic roll_at(input int target, output logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] start;
        bit r;
        int l;
        start = WIDTH'(target - lat);
        for (int k = 0; k < 1100 && mc != start; k++) tick();
        press_and_wait(5, 0, -1, r, l);
        chk("targeted rolled", int'(r), 1);
        c = mc;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        bit rolled;
        int l;
        logic [WIDTH-1:0] c;

        vecs[0] = '{width: 5, clear_at: -1, exp_roll: 1'b1, exp_valid: 1'b1};
        vecs[1] = '{width: 3, clear_at: -1, exp_roll: 1'b0, exp_valid: 1'b1};
        vecs[2] = '{width: 4, clear_at: -1, exp_roll: 1'b1, exp_valid: 1'b1};
        vecs[3] = '{width: 6, clear_at:  2, exp_roll: 1'b1, exp_valid: 1'b0};
        vecs[4] = '{width: 1, clear_at: -1, exp_roll: 1'b0, exp_valid: 1'b0};
        vecs[5] = '{width: 4, clear_at:  0, exp_roll: 1'b1, exp_valid: 1'b0};
        vecs[6] = '{width: 5, clear_at:  5, exp_roll: 1'b1, exp_valid: 1'b0};
        vecs[7] = '{width: 6, clear_at: -1, exp_roll: 1'b1, exp_valid: 1'b1};

        held        = '0;
        model_valid = 1'b0;
        model_rolls = 0;
        lat         = 0;
        rst         = 1'b1;
        bus.btn     = 1'b0;
        bus.clear   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        chk_quiet("reset");

        // Three 2-cycle glitches with 2-cycle gaps must not start a roll.
        for (int g = 0; g < 3; g++) begin
            bus.btn = 1'b1;
            repeat (2) tick();
            bus.btn = 1'b0;
            repeat (2) tick();
        end
        rolled = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (bus.busy) rolled = 1'b1;
            tick();
        end
        chk("glitch no roll", int'(rolled), 0);
        chk_quiet("glitch");

        // A single wide pulse gives exactly one roll.
        press_and_wait(5, 0, -1, rolled, lat);
        chk("wide pulse rolled", int'(rolled), 1);
        if (rolled) check_roll(mc, -1);
        rolled = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (bus.busy) rolled = 1'b1;
            tick();
        end
        chk("wide pulse single roll", int'(rolled), 0);

        roll_at(100, c);
        chk("entry count 100", int'(c), 100);
        check_roll(c, -1);
        chk("final 105", int'(bus.random_num), 105);
        repeat (8) tick();

        roll_at(1020, c);
        chk("entry count 1020", int'(c), 1020);
        check_roll(c, -1);
        chk("wrap final 1", int'(bus.random_num), 1);
        chk("wrap valid", int'(bus.valid), 1);
        repeat (8) tick();

        // clear held across the press cycle while in HOLD.
        press_and_wait(5, lat - 1, lat + 1, rolled, l);
        chk("clear beats press", int'(rolled), 0);
        held        = '0;
        model_valid = 1'b0;
        chk_quiet("clear+press");

        foreach (vecs[v]) begin
            press_and_wait(vecs[v].width, 0, -1, rolled, l);
            chk($sformatf("vec%0d rolled", v), int'(rolled), int'(vecs[v].exp_roll));
            if (rolled) begin
                check_roll(mc, vecs[v].clear_at);
                repeat (8) tick();
            end
            chk($sformatf("vec%0d valid", v), int'(bus.valid), int'(vecs[v].exp_valid));
            chk_quiet($sformatf("vec%0d", v));
        end

        for (int r = 0; r < 30; r++) begin
            int w, ca;
            w  = int'($urandom_range(1, 6));
            ca = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ROLL_LEN - 1)) : -1;
            press_and_wait(w, 0, -1, rolled, l);
            chk("rand rolled", int'(rolled), int'(w >= DEB));
            if (rolled) begin
                check_roll(mc, ca);
                repeat (8) tick();
            end
            chk_quiet("rand");
        end

        // rst in the middle of a roll.
        press_and_wait(5, 0, -1, rolled, l);
        chk("pre-rst rolled", int'(rolled), 1);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        held        = '0;
        model_valid = 1'b0;
        model_rolls = 0;
        chk_quiet("rst midroll");
        repeat (10) tick();

`ifdef RNG_ROLL_COUNT_EN
        chk("roll_count after rst", int'(bus.roll_count), 0);
        for (int r = 0; r < 300; r++) begin
            press_and_wait(5, 0, -1, rolled, l);
            if (!rolled) begin
                chk("count loop rolled", 0, 1);
                break;
            end
            for (int k = 0; k < 20 && !bus.valid; k++) tick();
            model_rolls++;
            if (r == 9) chk("roll_count 10", int'(bus.roll_count), 10);
            repeat (8) tick();
        end
        chk("roll_count saturated", int'(bus.roll_count), (model_rolls > 255) ? 255 : model_rolls);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("roll_count kept by clear", int'(bus.roll_count), 255);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
